msdft_cfg_sequencer: RTL and testbench

Sequencing stage directly downstream of the msdft_control AXI4-Lite register file: takes its four 32-bit register words and a write strobe and turns them into glitch-free configuration and control for the MSDFT datapath. Register writes are held as pending and applied only at a safe point: while idle, on restart, or at an accumulation boundary. The block also tracks position within each DFT window and accumulation run and flags window and accumulation ends.

---
 rtl/msdft_pkg.sv | 20 ++
 rtl/msdft_cfg_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_msdft_cfg_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/msdft_pkg.sv
// Shared definitions for the MSDFT control path: sequencer states, control-word bits
// and the register map offsets common with msdft_control.
package msdft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FILL = 2'd2,
    ST_RUN  = 2'd3
  } msdft_seq_state_t;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_RST_BIT = 1;

  localparam logic [3:0] REG_CTRL_OFS    = 4'h0;
  localparam logic [3:0] REG_DFT_LEN_OFS = 4'h4;
  localparam logic [3:0] REG_K_OFS       = 4'h8;
  localparam logic [3:0] REG_ACC_LEN_OFS = 4'hC;

endpackage

// File: rtl/msdft_cfg_sequencer.sv
// Turns register writes into glitch-free MSDFT config applied only at safe points; all outputs registered (1 cycle).
// No backpressure: din_valid is never stalled, writes wait as pending. win_last/acc_last flag the sample the next din_valid carries.
module msdft_cfg_sequencer
  import msdft_pkg::*;
#(
  parameter int DFT_LEN_W = 16,
  parameter int K_W       = 16,
  parameter int ACC_W     = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic [31:0]          reg_ctrl,
  input  logic [31:0]          reg_dft_len,
  input  logic [31:0]          reg_k,
  input  logic [31:0]          reg_acc_len,
  input  logic                 reg_wr,
  input  logic                 din_valid,
  output logic [DFT_LEN_W-1:0] cfg_dft_len,
  output logic [K_W-1:0]       cfg_k,
  output logic [ACC_W-1:0]     cfg_acc_len,
  output logic                 dft_rst,
  output logic                 dft_en,
  output logic                 out_gate,
  output logic [DFT_LEN_W-1:0] sample_idx,
  output logic                 win_last,
  output logic                 acc_last,
  output logic                 cfg_pending,
  output logic                 cfg_err
);

  msdft_seq_state_t state_q, state_d;

  logic [DFT_LEN_W-1:0] cfg_dft_len_q, cfg_dft_len_d;
  logic [K_W-1:0]       cfg_k_q, cfg_k_d;
  logic [ACC_W-1:0]     cfg_acc_len_q, cfg_acc_len_d;
  logic [DFT_LEN_W-1:0] pend_dft_len_q, pend_dft_len_d;
  logic [K_W-1:0]       pend_k_q, pend_k_d;
  logic [ACC_W-1:0]     pend_acc_len_q, pend_acc_len_d;
  logic                 cfg_pending_q, cfg_pending_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [DFT_LEN_W-1:0] sample_idx_q, sample_idx_d;
  logic [ACC_W-1:0]     acc_cnt_q, acc_cnt_d;
  logic                 ctrl_rst_prev_q;
  logic                 dft_rst_q, dft_rst_d;
  logic                 dft_en_q, dft_en_d;
  logic                 out_gate_q, out_gate_d;
  logic                 win_last_q, win_last_d;
  logic                 acc_last_q, acc_last_d;

  logic [DFT_LEN_W-1:0] wr_len;
  logic [K_W-1:0]       wr_k;
  logic [ACC_W-1:0]     wr_acc;
  logic                 wr_legal;
  logic                 cfg_legal;
  logic                 ctrl_en;
  logic                 rst_rise;
  logic                 idx_last;
  logic                 acc_wrap;
  logic                 unused_reg_bits;

  assign wr_len    = reg_dft_len[DFT_LEN_W-1:0];
  assign wr_k      = reg_k[K_W-1:0];
  assign wr_acc    = reg_acc_len[ACC_W-1:0];
  assign wr_legal  = (wr_len >= DFT_LEN_W'(2)) && (wr_acc != '0);
  assign cfg_legal = (cfg_dft_len_q >= DFT_LEN_W'(2)) && (cfg_acc_len_q != '0);
  assign ctrl_en   = reg_ctrl[CTRL_EN_BIT];
  assign rst_rise  = reg_ctrl[CTRL_RST_BIT] & ~ctrl_rst_prev_q;
  assign idx_last  = (sample_idx_q == cfg_dft_len_q - DFT_LEN_W'(1));
  assign acc_wrap  = (acc_cnt_q == cfg_acc_len_q - ACC_W'(1));

  assign unused_reg_bits = ^{reg_ctrl[31:2], reg_dft_len[31:DFT_LEN_W],
                             reg_k[31:K_W], reg_acc_len[31:ACC_W]};

  always_comb begin
    state_d        = state_q;
    cfg_dft_len_d  = cfg_dft_len_q;
    cfg_k_d        = cfg_k_q;
    cfg_acc_len_d  = cfg_acc_len_q;
    pend_dft_len_d = pend_dft_len_q;
    pend_k_d       = pend_k_q;
    pend_acc_len_d = pend_acc_len_q;
    cfg_pending_d  = cfg_pending_q;
    cfg_err_d      = cfg_err_q;
    sample_idx_d   = sample_idx_q;
    acc_cnt_d      = acc_cnt_q;

    // Pending config only ever reaches the datapath while it is stopped or being cleared.
    if (cfg_pending_q && (state_q == ST_IDLE || state_q == ST_LOAD)) begin
      cfg_dft_len_d = pend_dft_len_q;
      cfg_k_d       = pend_k_q;
      cfg_acc_len_d = pend_acc_len_q;
      cfg_pending_d = 1'b0;
    end

    if (reg_wr) begin
      if (wr_legal) begin
        pend_dft_len_d = wr_len;
        pend_k_d       = wr_k;
        pend_acc_len_d = wr_acc;
        cfg_pending_d  = 1'b1;
      end else begin
        cfg_err_d     = 1'b1;
        cfg_pending_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (ctrl_en && (cfg_pending_q || cfg_legal)) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_FILL;
      end
      ST_FILL: begin
        if (din_valid) begin
          if (idx_last) begin
            sample_idx_d = '0;
            state_d      = ST_RUN;
          end else begin
            sample_idx_d = sample_idx_q + DFT_LEN_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (din_valid) begin
          if (idx_last) begin
            sample_idx_d = '0;
            if (acc_wrap) begin
              acc_cnt_d = '0;
              // A write landing on the boundary sample counts as pending here.
              if (cfg_pending_q || (reg_wr && wr_legal)) state_d = ST_LOAD;
            end else begin
              acc_cnt_d = acc_cnt_q + ACC_W'(1);
            end
          end else begin
            sample_idx_d = sample_idx_q + DFT_LEN_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_IDLE && !ctrl_en) begin
      state_d = ST_IDLE;
    end else if ((state_q == ST_FILL || state_q == ST_RUN) && rst_rise) begin
      state_d = ST_LOAD;
    end

    if (state_d == ST_IDLE || state_d == ST_LOAD) begin
      sample_idx_d = '0;
      acc_cnt_d    = '0;
    end

    dft_rst_d  = (state_d == ST_LOAD);
    dft_en_d   = (state_d == ST_FILL) || (state_d == ST_RUN);
    out_gate_d = (state_d == ST_RUN);
    win_last_d = (state_d == ST_RUN) && (sample_idx_d == cfg_dft_len_d - DFT_LEN_W'(1));
    acc_last_d = win_last_d && (acc_cnt_d == cfg_acc_len_d - ACC_W'(1));
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q         <= ST_IDLE;
      cfg_dft_len_q   <= '0;
      cfg_k_q         <= '0;
      cfg_acc_len_q   <= '0;
      pend_dft_len_q  <= '0;
      pend_k_q        <= '0;
      pend_acc_len_q  <= '0;
      cfg_pending_q   <= 1'b0;
      cfg_err_q       <= 1'b0;
      sample_idx_q    <= '0;
      acc_cnt_q       <= '0;
      ctrl_rst_prev_q <= 1'b0;
      dft_rst_q       <= 1'b0;
      dft_en_q        <= 1'b0;
      out_gate_q      <= 1'b0;
      win_last_q      <= 1'b0;
      acc_last_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      cfg_dft_len_q   <= cfg_dft_len_d;
      cfg_k_q         <= cfg_k_d;
      cfg_acc_len_q   <= cfg_acc_len_d;
      pend_dft_len_q  <= pend_dft_len_d;
      pend_k_q        <= pend_k_d;
      pend_acc_len_q  <= pend_acc_len_d;
      cfg_pending_q   <= cfg_pending_d;
      cfg_err_q       <= cfg_err_d;
      sample_idx_q    <= sample_idx_d;
      acc_cnt_q       <= acc_cnt_d;
      ctrl_rst_prev_q <= reg_ctrl[CTRL_RST_BIT];
      dft_rst_q       <= dft_rst_d;
      dft_en_q        <= dft_en_d;
      out_gate_q      <= out_gate_d;
      win_last_q      <= win_last_d;
      acc_last_q      <= acc_last_d;
    end
  end

  assign cfg_dft_len = cfg_dft_len_q;
  assign cfg_k       = cfg_k_q;
  assign cfg_acc_len = cfg_acc_len_q;
  assign dft_rst     = dft_rst_q;
  assign dft_en      = dft_en_q;
  assign out_gate    = out_gate_q;
  assign sample_idx  = sample_idx_q;
  assign win_last    = win_last_q;
  assign acc_last    = acc_last_q;
  assign cfg_pending = cfg_pending_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_msdft_cfg_sequencer.sv
// Scoreboard bench for msdft_cfg_sequencer: a sample-count reference model predicts every cycle's outputs,
// a monitor pops and compares them after each rising edge.
module tb_msdft_cfg_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] reg_ctrl = '0, reg_dft_len = '0, reg_k = '0, reg_acc_len = '0;
  logic        reg_wr = 1'b0, din_valid = 1'b0;
  logic [15:0] cfg_dft_len, cfg_k, cfg_acc_len, sample_idx;
  logic        dft_rst, dft_en, out_gate, win_last, acc_last, cfg_pending, cfg_err;

  msdft_cfg_sequencer dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .reg_ctrl(reg_ctrl), .reg_dft_len(reg_dft_len), .reg_k(reg_k), .reg_acc_len(reg_acc_len),
    .reg_wr(reg_wr), .din_valid(din_valid),
    .cfg_dft_len(cfg_dft_len), .cfg_k(cfg_k), .cfg_acc_len(cfg_acc_len),
    .dft_rst(dft_rst), .dft_en(dft_en), .out_gate(out_gate), .sample_idx(sample_idx),
    .win_last(win_last), .acc_last(acc_last), .cfg_pending(cfg_pending), .cfg_err(cfg_err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [15:0] len;
    logic [15:0] k;
    logic [15:0] acc;
    logic        rst;
    logic        en;
    logic        gate;
    logic [15:0] idx;
    logic        wl;
    logic        al;
    logic        pend;
    logic        err;
  } obs_t;

  obs_t dut_obs;
  assign dut_obs = {cfg_dft_len, cfg_k, cfg_acc_len, dft_rst, dft_en, out_gate,
                    sample_idx, win_last, acc_last, cfg_pending, cfg_err};

  obs_t exp_q[$];
  obs_t cur_exp;
  int   checks = 0;
  int   failures = 0;
  bit   rstn_drv = 1'b0;

  // Reference model: the datapath is either stopped, being cleared, or has consumed m_seen samples since the clear.
  int m_n, m_k, m_acc, p_n, p_k, p_acc, m_seen;
  bit m_pend, m_err, m_run, m_load, m_prev;

  task automatic model_reset();
    m_n = 0; m_k = 0; m_acc = 0; p_n = 0; p_k = 0; p_acc = 0; m_seen = 0;
    m_pend = 0; m_err = 0; m_run = 0; m_load = 0; m_prev = 0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    int   idx;
    o = '0;
    o.len = 16'(m_n); o.k = 16'(m_k); o.acc = 16'(m_acc);
    o.pend = m_pend; o.err = m_err;
    o.rst = m_load;
    o.en = m_run;
    if (m_run) begin
      idx = (m_seen < m_n) ? m_seen : (m_seen - m_n) % m_n;
      o.idx  = 16'(idx);
      o.gate = (m_seen >= m_n);
      o.wl   = o.gate && (idx == m_n - 1);
      o.al   = o.wl && ((((m_seen - m_n) / m_n) % m_acc) == m_acc - 1);
    end
    return o;
  endfunction

  task automatic model_step();
    int wn, wk, wa;
    bit en, rise, wrl, idle, was_load, was_run, was_pend, act_ok, bnd;
    if (!ARESETN) begin
      model_reset();
      return;
    end
    wn = int'(reg_dft_len[15:0]); wk = int'(reg_k[15:0]); wa = int'(reg_acc_len[15:0]);
    en   = reg_ctrl[0];
    rise = reg_ctrl[1] && !m_prev;
    m_prev = reg_ctrl[1];
    wrl  = reg_wr && wn >= 2 && wa != 0;
    was_load = m_load; was_run = m_run; was_pend = m_pend;
    idle = !was_run && !was_load;
    act_ok = (m_n >= 2) && (m_acc >= 1);
    bnd = 0;
    if (was_run && din_valid && m_seen >= m_n)
      bnd = ((m_seen - m_n + 1) % (m_n * m_acc) == 0) && (was_pend || wrl);
    if (was_pend && (idle || was_load)) begin
      m_n = p_n; m_k = p_k; m_acc = p_acc; m_pend = 0;
    end
    if (reg_wr) begin
      if (wrl) begin p_n = wn; p_k = wk; p_acc = wa; m_pend = 1; end
      else begin m_err = 1; m_pend = 0; end
    end
    if (was_load) begin
      m_load = 0; m_run = en; m_seen = 0;
    end else if (!was_run) begin
      if (en && (was_pend || act_ok)) m_load = 1;
    end else if (!en) begin
      m_run = 0;
    end else if (rise) begin
      m_run = 0; m_load = 1;
    end else if (din_valid) begin
      if (bnd) begin m_run = 0; m_load = 1; end
      else m_seen++;
    end
  endtask

  task automatic drive(input bit [1:0] ctrl, input bit wr, input int n, input int k,
                       input int acc, input bit dv);
    logic [31:0] r;
    @(negedge ACLK);
    ARESETN = rstn_drv;
    r = $urandom(); reg_ctrl = {r[31:2], ctrl};
    reg_wr = wr;
    if (wr) begin
      r = $urandom(); reg_dft_len = {r[31:16], n[15:0]};
      r = $urandom(); reg_k       = {r[31:16], k[15:0]};
      r = $urandom(); reg_acc_len = {r[31:16], acc[15:0]};
    end
    din_valid = dv;
    model_step();
    cur_exp = model_obs();
    exp_q.push_back(cur_exp);
  endtask

  task automatic do_async_reset();
    @(negedge ACLK);
    #2;
    ARESETN = 1'b0; rstn_drv = 1'b0; reg_wr = 1'b0;
    #1;
    checks++;
    if (dut_obs !== '0) begin
      failures++;
      $display("FAIL async_reset outputs got=%h required=0", dut_obs);
    end
    model_reset();
    cur_exp = model_obs();
    exp_q.push_back(cur_exp);
  endtask

  // mode 0: until acc_last is presented; mode 1: until RUN sample 5 is presented
  task automatic run_until(input int mode, input int limit);
    bit hit = 0;
    for (int i = 0; i < limit && !hit; i++) begin
      hit = (mode == 0) ? cur_exp.al : (cur_exp.gate && cur_exp.idx == 16'd5);
      if (!hit) drive(2'b01, 0, 0, 0, 0, 1);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL wait_mode%0d got=timeout required=condition within %0d cycles", mode, limit);
    end
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(posedge ACLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (dut_obs !== e) begin
          failures++;
          $display("FAIL outputs t=%0t got len=%0d k=%0d acc=%0d rst=%b en=%b gate=%b idx=%0d wl=%b al=%b pend=%b err=%b required len=%0d k=%0d acc=%0d rst=%b en=%b gate=%b idx=%0d wl=%b al=%b pend=%b err=%b",
                   $time, dut_obs.len, dut_obs.k, dut_obs.acc, dut_obs.rst, dut_obs.en, dut_obs.gate,
                   dut_obs.idx, dut_obs.wl, dut_obs.al, dut_obs.pend, dut_obs.err,
                   e.len, e.k, e.acc, e.rst, e.en, e.gate, e.idx, e.wl, e.al, e.pend, e.err);
        end
      end
    end
  end

  initial begin : stimulus
    bit [1:0] ctrl;
    model_reset();
    rstn_drv = 1'b0;
    repeat (3) drive(2'b00, 0, 0, 0, 0, 0);
    rstn_drv = 1'b1;

    drive(2'b00, 1, 8, 3, 2, 0);
    repeat (2) drive(2'b00, 0, 0, 0, 0, 0);
    repeat (8 + 32 + 4) drive(2'b01, 0, 0, 0, 0, 1);

    run_until(1, 100);
    drive(2'b11, 0, 0, 0, 0, 1);
    repeat (14) drive(2'b01, 0, 0, 0, 0, 1);

    drive(2'b01, 1, 4, 5, 2, 1);
    repeat (50) drive(2'b01, 0, 0, 0, 0, 1);

    drive(2'b01, 1, 1, 7, 2, 1);
    repeat (6) drive(2'b01, 0, 0, 0, 0, 1);

    drive(2'b01, 1, 6, 9, 1, 0);
    run_until(0, 100);
    drive(2'b00, 0, 0, 0, 0, 1);
    repeat (4) drive(2'b00, 0, 0, 0, 0, 0);

    repeat (3) drive(2'b01, 0, 0, 0, 0, 1);
    run_until(0, 100);
    drive(2'b01, 1, 3, 2, 1, 1);
    repeat (2) drive(2'b01, 0, 0, 0, 0, 1);
    do_async_reset();
    drive(2'b01, 0, 0, 0, 0, 1);
    rstn_drv = 1'b1;
    repeat (4) drive(2'b01, 0, 0, 0, 0, 1);

    ctrl = 2'b01;
    for (int i = 0; i < 4000; i++) begin
      ctrl[0] = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) ctrl[1] = ~ctrl[1];
      if ($urandom_range(0, 1499) == 0) begin
        do_async_reset();
        drive(ctrl, 0, 0, 0, 0, 0);
        rstn_drv = 1'b1;
      end else begin
        drive(ctrl, ($urandom_range(0, 24) == 0), $urandom_range(0, 6), $urandom_range(0, 65535),
              $urandom_range(0, 3), ($urandom_range(0, 3) != 0));
      end
    end

    repeat (2) @(posedge ACLK);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending entries required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
